// File: rtl/opc5_uart_mmio.sv
// OPC5 memory-mapped UART: byte transmitter, byte receiver with a small RX FIFO,
// sticky error flags and an RX interrupt. Reads are combinational for the CPU's one-cycle read.
module opc5_uart_mmio #(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter int          CLK_DIV   = 434,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        rnw,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int PW  = $clog2(RX_DEPTH);
    localparam int PW1 = PW + 1;
    localparam logic [CW-1:0]  DIV_M1  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [PW1-1:0] DEPTH_C = PW1'(RX_DEPTH);
    localparam logic [PW1-1:0] CNT1    = PW1'(1);
    localparam logic [PW-1:0]  PTR1    = PW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic sel, wr_tx, wr_stat, rd_rx;
    logic unused_bits;

    assign sel         = (address[15:2] == BASE_ADDR[15:2]);
    assign data_oe     = sel & rnw;
    assign wr_tx       = sel & ~rnw & (address[1:0] == 2'd0);
    assign wr_stat     = sel & ~rnw & (address[1:0] == 2'd2);
    assign rd_rx       = sel & rnw & (address[1:0] == 2'd1);
    assign unused_bits = ^data_in[15:8];

    // ---------------- transmitter ----------------
    uart_state_t   tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic          txd_reg, txd_next;
    logic          tx_busy;

    assign tx_busy = (tx_state_reg != IDLE);
    assign txd     = txd_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        case (tx_state_reg)
            IDLE: begin
                if (wr_tx) begin
                    tx_state_next = START;
                    tx_shift_next = data_in[7:0];
                    tx_cnt_next   = DIV_M1;
                    txd_next      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_reg == '0) begin
                    tx_state_next = DATA;
                    tx_cnt_next   = DIV_M1;
                    tx_bit_next   = 3'd0;
                    txd_next      = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg - CNT_ONE;
                end
            end
            DATA: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next = DIV_M1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = STOP;
                        txd_next      = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - CNT_ONE;
                end
            end
            STOP: begin
                if (tx_cnt_reg == '0) tx_state_next = IDLE;
                else                  tx_cnt_next   = tx_cnt_reg - CNT_ONE;
            end
        endcase
    end

    // ---------------- receiver ----------------
    logic          rx_meta_reg, rs_reg, rs_prev_reg;
    uart_state_t   rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rs_reg       <= 1'b1;
            rs_prev_reg  <= 1'b1;
            rx_state_reg <= IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg  <= rxd;
            rs_reg       <= rx_meta_reg;
            rs_prev_reg  <= rs_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // Only a fresh high-to-low edge starts a frame, so a line stuck low never retriggers.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                if (rs_prev_reg && !rs_reg) begin
                    rx_state_next = START;
                    rx_cnt_next   = HALF_M1;
                end
            end
            START: begin
                if (rx_cnt_reg == '0) begin
                    if (!rs_reg) begin
                        rx_state_next = DATA;
                        rx_cnt_next   = DIV_M1;
                        rx_bit_next   = 3'd0;
                    end else begin
                        rx_state_next = IDLE;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - CNT_ONE;
                end
            end
            DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_shift_next = {rs_reg, rx_shift_reg[7:1]};
                    rx_cnt_next   = DIV_M1;
                    if (rx_bit_reg == 3'd7) rx_state_next = STOP;
                    else                    rx_bit_next   = rx_bit_reg + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt_reg - CNT_ONE;
                end
            end
            STOP: begin
                if (rx_cnt_reg == '0) begin
                    rx_done       = 1'b1;
                    rx_state_next = IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg - CNT_ONE;
                end
            end
        endcase
    end

    // ---------------- RX FIFO and status ----------------
    logic [7:0]     fifo_mem [RX_DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PW1-1:0] count_reg, count_next;
    logic           overrun_reg, frame_err_reg, irq_reg;
    logic           rx_avail, rx_full, pop, push, overrun_set, frame_set;

    assign rx_avail    = (count_reg != '0);
    assign rx_full     = (count_reg == DEPTH_C);
    assign pop         = rd_rx & rx_avail;
    assign push        = rx_done & rs_reg & (~rx_full | pop);
    assign overrun_set = rx_done & rs_reg & rx_full & ~pop;
    assign frame_set   = rx_done & ~rs_reg;
    assign irq         = irq_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)      count_next = count_reg + CNT1;
        else if (!push && pop) count_next = count_reg - CNT1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR1;
            count_reg     <= count_next;
            overrun_reg   <= overrun_set | (overrun_reg & ~(wr_stat & data_in[3]));
            frame_err_reg <= frame_set | (frame_err_reg & ~(wr_stat & data_in[4]));
            irq_reg       <= (count_next != '0);
        end
    end

    always_comb begin
        data_out = 16'h0000;
        if (data_oe) begin
            case (address[1:0])
                2'd1: if (rx_avail) data_out = {8'h00, fifo_mem[rd_ptr_reg]};
                2'd2: data_out = {11'b0, frame_err_reg, overrun_reg, rx_full, rx_avail, tx_busy};
                default: data_out = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_opc5_uart_mmio.sv
// Bench for opc5_uart_mmio: frame-level model (bit queues, byte FIFO, sticky flags)
// compared against the DUT every cycle, plus directed literal expectations.
module tb_opc5_uart_mmio;
    localparam int CLK_DIV  = 4;
    localparam int RX_DEPTH = 4;
    localparam int GAP      = 4;
    localparam logic [15:0] IDLE_ADDR = 16'h1234;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        rnw;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic        rxd;
    logic        txd;
    logic        irq;

    always #5 clk = ~clk;

    opc5_uart_mmio #(
        .BASE_ADDR(16'hFE00),
        .CLK_DIV  (CLK_DIV),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rnw     (rnw),
        .data_in (data_in),
        .data_out(data_out),
        .data_oe (data_oe),
        .rxd     (rxd),
        .txd     (txd),
        .irq     (irq)
    );

    typedef struct {
        logic       lvl;
        bit         ev;
        logic [7:0] data;
        bit         stop_ok;
    } rx_elem_t;

    // model state
    bit          tx_q[$];
    logic [7:0]  fifo_q[$];
    bit          m_ov;
    bit          m_fe;
    rx_elem_t    rx_wave[$];
    logic        rxd_nxt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_rd;
    bit          cap_on   = 1'b0;
    int          cap_idx  = 0;
    logic [39:0] cap;
    logic [7:0]  rx_bytes [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs();
        logic        sel;
        logic        e_txd;
        logic [15:0] e_stat;
        bit          rx_ok;
        sel    = (address[15:2] == 14'h3F80);
        rx_ok  = (rx_wave.size() == 0) || (rx_wave.size() > 8);
        e_txd  = (tx_q.size() != 0) ? tx_q[0] : 1'b1;
        e_stat = {11'b0, m_fe, m_ov, fifo_q.size() == RX_DEPTH, fifo_q.size() != 0, tx_q.size() != 0};
        chk("data_oe", 64'(data_oe), 64'(sel & rnw));
        chk("txd", 64'(txd), 64'(e_txd));
        if (rx_ok) chk("irq", 64'(irq), 64'(fifo_q.size() != 0));
        if (sel && rnw) begin
            case (address[1:0])
                2'd1: if (rx_ok) chk("rd_rxdata", 64'(data_out),
                                     (fifo_q.size() != 0) ? 64'(fifo_q[0]) : 64'd0);
                2'd2: if (rx_ok) chk("rd_status", 64'(data_out), 64'(e_stat));
                default: chk("rd_zero", 64'(data_out), 64'd0);
            endcase
        end
        last_rd = data_out;
        if (cap_on && cap_idx < 40) begin
            cap[cap_idx] = txd;
            cap_idx++;
        end
    endtask

    task automatic model_edge();
        bit         was_busy;
        logic       sel;
        rx_elem_t   e;
        rxd_nxt = 1'b1;
        if (reset) return;
        sel      = (address[15:2] == 14'h3F80);
        was_busy = (tx_q.size() != 0);
        if (was_busy) void'(tx_q.pop_front());
        if (sel && !rnw && address[1:0] == 2'd0 && !was_busy) begin
            for (int i = 0; i < CLK_DIV; i++) tx_q.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < CLK_DIV; i++) tx_q.push_back(data_in[b]);
            for (int i = 0; i < CLK_DIV; i++) tx_q.push_back(1'b1);
        end
        if (sel && !rnw && address[1:0] == 2'd2) begin
            if (data_in[4]) m_fe = 1'b0;
            if (data_in[3]) m_ov = 1'b0;
        end
        if (sel && rnw && address[1:0] == 2'd1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (rx_wave.size() != 0) begin
            e = rx_wave.pop_front();
            rxd_nxt = e.lvl;
            if (e.ev) begin
                if (!e.stop_ok)                     m_fe = 1'b1;
                else if (fifo_q.size() == RX_DEPTH) m_ov = 1'b1;
                else                                fifo_q.push_back(e.data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
        rxd = rxd_nxt;
    endtask

    task automatic access(input logic [15:0] a, input logic r, input logic [15:0] d);
        address = a;
        rnw     = r;
        data_in = d;
        tick();
        address = IDLE_ADDR;
        rnw     = 1'b1;
        data_in = 16'h0000;
    endtask

    task automatic push_rx(input logic lvl, input bit ev, input logic [7:0] d, input bit ok);
        rx_elem_t e;
        e.lvl = lvl; e.ev = ev; e.data = d; e.stop_ok = ok;
        rx_wave.push_back(e);
    endtask

    task automatic enqueue_frame(input logic [7:0] d, input bit ok);
        for (int i = 0; i < CLK_DIV; i++) push_rx(1'b0, 1'b0, d, ok);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < CLK_DIV; i++) push_rx(d[b], 1'b0, d, ok);
        for (int i = 0; i < CLK_DIV; i++) push_rx(ok, 1'b0, d, ok);
        for (int i = 0; i < GAP; i++) push_rx(1'b1, i == GAP - 1, d, ok);
    endtask

    task automatic enqueue_glitch();
        push_rx(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) push_rx(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic wait_rx();
        for (int i = 0; i < 200 && rx_wave.size() != 0; i++) tick();
        chk("rx_wave_drained", 64'(rx_wave.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        int          kind;
        bit          settled;
        reset   = 1'b1;
        rxd     = 1'b1;
        rxd_nxt = 1'b1;
        address = IDLE_ADDR;
        rnw     = 1'b1;
        data_in = 16'h0000;
        m_ov    = 1'b0;
        m_fe    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("reset_txd", 64'(txd), 64'd1);
        chk("reset_irq", 64'(irq), 64'd0);
        access(16'hFE02, 1'b1, 16'h0000);
        chk("reset_status", 64'(last_rd), 64'h0000);

        // TX of A5 with a dropped write mid-frame
        access(16'hFE00, 1'b0, 16'h00A5);
        cap_idx = 0;
        cap_on  = 1'b1;
        access(16'hFE00, 1'b0, 16'h0041);
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_busy", 64'(last_rd), 64'h0001);
        for (int i = 0; i < 100 && cap_idx < 40; i++) tick();
        cap_on = 1'b0;
        chk("tx_a5_wave", 64'(cap), 64'hFF0F00F0F0);
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_tx_done", 64'(last_rd), 64'h0000);

        // RX of 3C
        enqueue_frame(8'h3C, 1'b1);
        wait_rx();
        chk("irq_after_rx", 64'(irq), 64'd1);
        access(16'hFE01, 1'b1, 16'h0000);
        chk("rx_3c", 64'(last_rd), 64'h003C);
        chk("irq_after_pop", 64'(irq), 64'd0);
        access(16'hFE01, 1'b1, 16'h0000);
        chk("rx_empty_read", 64'(last_rd), 64'h0000);

        // five frames into a four-deep FIFO
        for (int f = 0; f < 5; f++) begin
            rx_bytes[f] = 8'($urandom);
            enqueue_frame(rx_bytes[f], 1'b1);
            wait_rx();
        end
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_overrun", 64'(last_rd), 64'h000E);
        for (int f = 0; f < 4; f++) begin
            access(16'hFE01, 1'b1, 16'h0000);
            chk("rx_order", 64'(last_rd), 64'({8'h00, rx_bytes[f]}));
        end
        access(16'hFE02, 1'b0, 16'h0008);
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_ov_cleared", 64'(last_rd), 64'h0000);

        // bad stop bit, then a glitch
        enqueue_frame(8'h5A, 1'b0);
        wait_rx();
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_frame_err", 64'(last_rd), 64'h0010);
        chk("irq_frame_err", 64'(irq), 64'd0);
        access(16'hFE02, 1'b0, 16'h0010);
        enqueue_glitch();
        wait_rx();
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_glitch", 64'(last_rd), 64'h0000);

        // reset mid-TX and mid-RX with data in the FIFO
        enqueue_frame(8'h77, 1'b1);
        wait_rx();
        access(16'hFE00, 1'b0, 16'h0000);
        enqueue_frame(8'hC3, 1'b1);
        repeat (10) tick();
        chk("txd_low_pre_reset", 64'(txd), 64'd0);
        reset = 1'b1;
        #1;
        chk("reset_async_txd", 64'(txd), 64'd1);
        tx_q.delete();
        fifo_q.delete();
        rx_wave.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        rxd  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        access(16'hFE02, 1'b1, 16'h0000);
        chk("status_post_reset", 64'(last_rd), 64'h0000);
        chk("irq_post_reset", 64'(irq), 64'd0);
        access(16'hFE01, 1'b1, 16'h0000);
        chk("fifo_post_reset", 64'(last_rd), 64'h0000);

        // decode boundaries
        address = 16'hFE04; rnw = 1'b1;
        #1 chk("oe_fe04", 64'(data_oe), 64'd0);
        tick();
        address = 16'h0000;
        #1 chk("oe_0000", 64'(data_oe), 64'd0);
        tick();
        address = 16'hFE03;
        #1 chk("oe_fe03", 64'(data_oe), 64'd1);
        chk("rd_fe03", 64'(data_out), 64'd0);
        tick();
        address = IDLE_ADDR;

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            if (rx_wave.size() == 0 && $urandom_range(0, 5) == 0) begin
                kind = int'($urandom_range(0, 9));
                if (kind == 0) enqueue_glitch();
                else           enqueue_frame(8'($urandom), kind != 1);
            end
            settled = (rx_wave.size() == 0);
            case ($urandom_range(0, 8))
                0: access(16'hFE00, 1'b0, 16'($urandom));
                1: access(($urandom_range(0, 1) != 0) ? 16'hFE00 : 16'hFE03, 1'b1, 16'h0000);
                2: begin
                    ra = 16'($urandom);
                    if (ra[15:2] == 14'h3F80) ra[8] = ~ra[8];
                    access(ra, 1'b1, 16'($urandom));
                end
                3: if (settled) access(16'hFE01, 1'b1, 16'h0000); else tick();
                4: if (settled) access(16'hFE02, 1'b1, 16'h0000); else tick();
                5: if (settled) access(16'hFE02, 1'b0, 16'($urandom)); else tick();
                6: access(($urandom_range(0, 1) != 0) ? 16'hFE01 : 16'hFE03, 1'b0, 16'($urandom));
                default: tick();
            endcase
        end
        wait_rx();
        repeat (50) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
